// File: rtl/banco_registradores_pkg.sv
// Constants and helpers shared by the register file, the operand multiplexer and the control unit.
// Width, register count and the program-counter index all live here.
package banco_registradores_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int PC_INDEX = NUM_REGS - 1;

    typedef logic [NUM_REGS-1:0] reg_sel_t;

    // True when more than one register is selected by a write-enable vector
    function automatic logic is_multi_hot(input reg_sel_t sel);
        return (sel & (sel - reg_sel_t'(1))) != '0;
    endfunction

endpackage : banco_registradores_pkg

// File: rtl/banco_registradores_registrador_n.sv
// Plain DATA_W-bit register with load enable and asynchronous active-low reset.
// Used for the general-purpose registers R0..R6.
module registrador_n #(
    parameter int                DATA_W    = banco_registradores_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : registrador_n

// File: rtl/banco_registradores.sv
// Eight-register file of the 16-bit processor; R7 is the program counter (load beats increment).
// Also keeps two sticky status flags: PC wrap-around and multi-register write.
module banco_registradores #(
    parameter int                DATA_W   = banco_registradores_pkg::DATA_W,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [DATA_W-1:0] R_RESET  = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [7:0]        rin,
    input  logic              incr_pc,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic              pc_wrap,
    output logic              wr_multi
);

    import banco_registradores_pkg::*;

    localparam logic [DATA_W-1:0] PC_STEP = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] w_regs [PC_INDEX];
    logic [DATA_W-1:0] r_pc;
    logic              r_pc_wrap;
    logic              r_wr_multi;
    logic              w_pc_load;
    logic              w_pc_incr;
    logic              w_pc_at_max;

    genvar gi;
    generate
        for (gi = 0; gi < PC_INDEX; gi++) begin : g_gpr
            registrador_n #(
                .DATA_W    (DATA_W),
                .RESET_VAL (R_RESET)
            ) u_reg (
                .clock  (clock),
                .resetn (resetn),
                .i_en   (rin[gi]),
                .i_d    (bus_in),
                .o_q    (w_regs[gi])
            );
        end
    endgenerate

    assign w_pc_load   = rin[PC_INDEX];
    assign w_pc_incr   = incr_pc && !w_pc_load;
    assign w_pc_at_max = &r_pc;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc <= PC_RESET;
        end else if (w_pc_load) begin
            r_pc <= bus_in;
        end else if (w_pc_incr) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Wrap counts only for an increment out of all-ones; a jump to zero does not set it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc_wrap  <= 1'b0;
            r_wr_multi <= 1'b0;
        end else begin
            if (w_pc_incr && w_pc_at_max) begin
                r_pc_wrap <= 1'b1;
            end
            if (is_multi_hot(reg_sel_t'(rin))) begin
                r_wr_multi <= 1'b1;
            end
        end
    end

    assign r0       = w_regs[0];
    assign r1       = w_regs[1];
    assign r2       = w_regs[2];
    assign r3       = w_regs[3];
    assign r4       = w_regs[4];
    assign r5       = w_regs[5];
    assign r6       = w_regs[6];
    assign r7       = r_pc;
    assign pc_wrap  = r_pc_wrap;
    assign wr_multi = r_wr_multi;

endmodule : banco_registradores

// File: tb/tb_banco_registradores.sv
// Randomized and directed bench for the register file against an array-based reference model.
module tb_banco_registradores;

    localparam logic [15:0] PC_RST = 16'h0040;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] bus_in;
    logic [7:0]  rin;
    logic        incr_pc;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic        pc_wrap, wr_multi;
    logic [15:0] w_obs [8];

    int n_checks   = 0;
    int n_failures = 0;

    logic [15:0] m_reg [8];
    logic        m_wrap;
    logic        m_multi;

    always #5 clock = ~clock;

    banco_registradores #(
        .DATA_W   (16),
        .PC_RESET (PC_RST),
        .R_RESET  (16'h0000)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus_in   (bus_in),
        .rin      (rin),
        .incr_pc  (incr_pc),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .r4       (r4),
        .r5       (r5),
        .r6       (r6),
        .r7       (r7),
        .pc_wrap  (pc_wrap),
        .wr_multi (wr_multi)
    );

    assign w_obs[0] = r0;
    assign w_obs[1] = r1;
    assign w_obs[2] = r2;
    assign w_obs[3] = r3;
    assign w_obs[4] = r4;
    assign w_obs[5] = r5;
    assign w_obs[6] = r6;
    assign w_obs[7] = r7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 7; k++) m_reg[k] = 16'h0000;
        m_reg[7] = PC_RST;
        m_wrap   = 1'b0;
        m_multi  = 1'b0;
    endtask

    // Reference behaviour for one rising edge, taken straight from the register-file rules
    task automatic model_edge(input logic [15:0] b, input logic [7:0] r, input logic inc);
        if (!resetn) return;
        for (int k = 0; k < 7; k++) if (r[k]) m_reg[k] = b;
        if (r[7]) begin
            m_reg[7] = b;
        end else if (inc) begin
            if (m_reg[7] == 16'hFFFF) m_wrap = 1'b1;
            m_reg[7] = 16'((int'(m_reg[7]) + 1) % 65536);
        end
        if ($countones(r) > 1) m_multi = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s r%0d", tag, k), 32'(w_obs[k]), 32'(m_reg[k]));
        check({tag, " pc_wrap"}, 32'(pc_wrap), 32'(m_wrap));
        check({tag, " wr_multi"}, 32'(wr_multi), 32'(m_multi));
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one
    task automatic cycle(input logic [15:0] b, input logic [7:0] r, input logic inc, input string tag);
        bus_in  = b;
        rin     = r;
        incr_pc = inc;
        #1;
        compare_all({tag, " pre"});
        @(posedge clock);
        model_edge(b, r, inc);
        #1;
        compare_all(tag);
        $display("txn %-10s bus=%h rin=%h inc=%0d r7=%h wrap=%0d multi=%0d",
                 tag, b, r, inc, r7, pc_wrap, wr_multi);
    endtask

    // Asserts reset mid-cycle with busy inputs and releases it mid-cycle with idle inputs
    task automatic mid_reset(input string tag);
        bus_in  = 16'($urandom);
        rin     = 8'hFF;
        incr_pc = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all({tag, " async"});
        cycle(16'($urandom), 8'hFF, 1'b1, {tag, " held"});
        #2;
        rin     = 8'h00;
        incr_pc = 1'b0;
        resetn  = 1'b1;
        @(posedge clock);
        #1;
        compare_all({tag, " rel"});
        $display("txn %-10s reset applied and released", tag);
    endtask

    initial begin
        logic [7:0]  r_sel;
        logic [15:0] b_val;
        logic        inc;

        resetn  = 1'b0;
        bus_in  = 16'h0000;
        rin     = 8'h00;
        incr_pc = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all("por");
        resetn = 1'b1;

        // Write/readback of R3
        cycle(16'hBEEF, 8'h08, 1'b0, "wr_r3");
        check("wr_r3 value", 32'(r3), 32'h0000_BEEF);
        cycle(16'h0000, 8'h00, 1'b0, "idle");

        // PC load then three increments
        cycle(16'h0010, 8'h80, 1'b0, "ld_pc");
        for (int i = 0; i < 3; i++) cycle(16'hAAAA, 8'h00, 1'b1, "inc_pc");
        check("inc3 r7", 32'(r7), 32'h0000_0013);
        check("inc3 wrap", 32'(pc_wrap), 32'h0);

        // Load wins over increment
        cycle(16'h0200, 8'h80, 1'b1, "ld_vs_inc");
        check("ld_vs_inc r7", 32'(r7), 32'h0000_0200);

        // Jump to zero is not a wrap
        cycle(16'h0000, 8'h80, 1'b1, "ld_zero");
        check("ld_zero wrap", 32'(pc_wrap), 32'h0);

        // Wrap from all-ones
        cycle(16'hFFFF, 8'h80, 1'b0, "ld_ffff");
        cycle(16'h5555, 8'h00, 1'b1, "wrap");
        check("wrap r7", 32'(r7), 32'h0);
        check("wrap flag", 32'(pc_wrap), 32'h1);
        for (int i = 0; i < 5; i++) cycle(16'h0000, 8'h00, 1'b0, "idle");
        check("wrap sticky", 32'(pc_wrap), 32'h1);

        // Multi-hot write and sticky flag
        cycle(16'h1234, 8'h05, 1'b0, "multi");
        check("multi r0", 32'(r0), 32'h0000_1234);
        check("multi r2", 32'(r2), 32'h0000_1234);
        check("multi flag", 32'(wr_multi), 32'h1);
        cycle(16'h4321, 8'h02, 1'b0, "single");
        check("multi sticky", 32'(wr_multi), 32'h1);

        mid_reset("rst1");
        check("rst1 r7", 32'(r7), 32'(PC_RST));

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 4))
                0:       r_sel = 8'h00;
                1, 2:    r_sel = 8'(1 << $urandom_range(0, 7));
                3:       r_sel = 8'($urandom);
                default: r_sel = 8'h80;
            endcase
            case ($urandom_range(0, 7))
                0:       b_val = 16'hFFFF;
                1:       b_val = 16'hFFFE;
                default: b_val = 16'($urandom);
            endcase
            inc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) mid_reset("rnd_rst");
            else cycle(b_val, r_sel, inc, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule : tb_banco_registradores
